mesh_term_src: RTL and testbench

- Per-terminal ingress stage that sits directly upstream of one mesh_gnrtr terminal port.
- Accepts host transactions (destination row/col, mode, payload) and assembles them into pckg_sz-bit mesh packets.
- Buffers packets in a FIFO and presents the head packet to the mesh via data_out_i_in/pndng_i_in; the mesh consumes it with popin.
- One instance per terminal; 16 instances feed a 4x4 mesh.

---
 rtl/mesh_term_src_if.sv | 24 ++
 rtl/mesh_term_src.sv | 118 +++++++++++
 tb/tb_mesh_term_src.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/mesh_term_src_if.sv
// Host-write and mesh-ingress signal bundle for one mesh_term_src terminal.
interface mesh_term_src_if #(
  parameter int pckg_sz = 40
) ();
  logic                 push;
  logic [3:0]           dest_row;
  logic [3:0]           dest_col;
  logic                 mode;
  logic [pckg_sz-17:0]  payload;
  logic                 full;
  logic [pckg_sz-1:0]   data_out_i_in;
  logic                 pndng_i_in;
  logic                 popin;

  modport master (
    output push, dest_row, dest_col, mode, payload, popin,
    input  full, data_out_i_in, pndng_i_in
  );

  modport slave (
    input  push, dest_row, dest_col, mode, payload, popin,
    output full, data_out_i_in, pndng_i_in
  );
endinterface

// File: rtl/mesh_term_src.sv
// Terminal ingress: packs host pushes into mesh packets, FWFT FIFO toward the mesh, watchdog.
// Optional broadcast destination (4'hF/4'hF) and bcast_cnt port via `MESH_TERM_SRC_BCAST_EN.
module mesh_term_src #(
  parameter int pckg_sz     = 40,
  parameter int fifo_depth  = 4,
  parameter int ROWS        = 4,
  parameter int COLUMS      = 4,
  parameter int STALL_LIMIT = 50
) (
  input  logic              clk,
  input  logic              reset,
  mesh_term_src_if.slave    bus,
  output logic              overflow,
  output logic              bad_dest,
  output logic              stall,
  output logic [15:0]       sent_cnt
`ifdef MESH_TERM_SRC_BCAST_EN
  ,
  output logic [15:0]       bcast_cnt
`endif
);

  localparam int AW = $clog2(fifo_depth);
  localparam int WW = $clog2(STALL_LIMIT + 1);
  localparam logic [AW:0]   DEPTH   = (AW+1)'(fifo_depth);
  localparam logic [WW-1:0] WD_MAX  = WW'(STALL_LIMIT);
  localparam logic [3:0]    ROW_MAX = 4'(ROWS + 1);
  localparam logic [3:0]    COL_MAX = 4'(COLUMS + 1);

  logic [pckg_sz-1:0] mem [fifo_depth];
  logic [AW-1:0]      wr_ptr, rd_ptr, rd_ptr_inc;
  logic [AW:0]        count, count_n;
  logic [WW-1:0]      wd_cnt;
  logic               legal, is_bcast, pop, acc, mode_eff;
  logic [pckg_sz-1:0] pkt, head_n;
  logic               unused_pay_msb;

  assign unused_pay_msb = bus.payload[pckg_sz-17];
  assign rd_ptr_inc     = rd_ptr + AW'(1);

  always_comb begin
    is_bcast = 1'b0;
`ifdef MESH_TERM_SRC_BCAST_EN
    is_bcast = (bus.dest_row == 4'hF) && (bus.dest_col == 4'hF);
`endif
    legal    = is_bcast ||
               ((bus.dest_row <= ROW_MAX) && (bus.dest_col <= COL_MAX) &&
                !((bus.dest_row == 4'h0) && (bus.dest_col == 4'h0)));
    mode_eff = bus.mode && !is_bcast;
    pkt      = {8'h00, bus.dest_row, bus.dest_col, mode_eff, bus.payload[pckg_sz-18:0]};
    pop      = bus.popin && bus.pndng_i_in;
    acc      = bus.push && legal && (!bus.full || pop);
    count_n  = count + (AW+1)'(acc) - (AW+1)'(pop);
    // Registered FWFT head: choose what sits at the head after this edge.
    head_n   = bus.data_out_i_in;
    if (pop) begin
      if (count > (AW+1)'(1))
        head_n = mem[rd_ptr_inc];
      else if (acc)
        head_n = pkt;
    end else if ((count == '0) && acc) begin
      head_n = pkt;
    end
  end

  always_ff @(posedge clk) begin
    if (acc)
      mem[wr_ptr] <= pkt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      count             <= '0;
      bus.full          <= 1'b0;
      bus.pndng_i_in    <= 1'b0;
      bus.data_out_i_in <= '0;
      overflow          <= 1'b0;
      bad_dest          <= 1'b0;
      stall             <= 1'b0;
      sent_cnt          <= '0;
      wd_cnt            <= '0;
`ifdef MESH_TERM_SRC_BCAST_EN
      bcast_cnt         <= '0;
`endif
    end else begin
      if (acc)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr_inc;
      count             <= count_n;
      bus.full          <= (count_n == DEPTH);
      bus.pndng_i_in    <= (count_n != '0);
      bus.data_out_i_in <= head_n;
      if (bus.push && !legal)
        bad_dest <= 1'b1;
      if (bus.push && legal && bus.full && !pop)
        overflow <= 1'b1;
      if (pop)
        sent_cnt <= sent_cnt + 16'd1;
      // Watchdog saturates at the limit; stall latches on the edge it gets there.
      if (bus.pndng_i_in && !bus.popin) begin
        if (wd_cnt != WD_MAX)
          wd_cnt <= wd_cnt + WW'(1);
        if (wd_cnt >= WD_MAX - WW'(1))
          stall <= 1'b1;
      end else begin
        wd_cnt <= '0;
      end
`ifdef MESH_TERM_SRC_BCAST_EN
      if (acc && is_bcast)
        bcast_cnt <= bcast_cnt + 16'd1;
`endif
    end
  end

endmodule

// File: tb/tb_mesh_term_src.sv
// Self-checking bench for mesh_term_src: queue-based reference model plus directed literal checks.
module tb_mesh_term_src;
  localparam int PW = 40;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        overflow, bad_dest, stall;
  logic [15:0] sent_cnt;
`ifdef MESH_TERM_SRC_BCAST_EN
  logic [15:0] bcast_cnt;
`endif

  mesh_term_src_if #(.pckg_sz(PW)) bif ();

  mesh_term_src #(
    .pckg_sz(PW), .fifo_depth(4), .ROWS(4), .COLUMS(4), .STALL_LIMIT(50)
  ) dut (
    .clk(clk), .reset(reset), .bus(bif),
    .overflow(overflow), .bad_dest(bad_dest), .stall(stall), .sent_cnt(sent_cnt)
`ifdef MESH_TERM_SRC_BCAST_EN
    , .bcast_cnt(bcast_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  // Reference model: a queue of packets plus plain counters.
  logic [PW-1:0] mq[$];
  logic [PW-1:0] m_head = '0;
  bit            m_ovf, m_bad, m_stall;
  int            m_sent, m_wd, m_bc;

  function automatic bit is_bc(input logic [3:0] r, input logic [3:0] c);
`ifdef MESH_TERM_SRC_BCAST_EN
    return (r == 4'hF) && (c == 4'hF);
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit legal_dest(input logic [3:0] r, input logic [3:0] c);
    if (is_bc(r, c)) return 1'b1;
    return (r <= 5) && (c <= 5) && !((r == 0) && (c == 0));
  endfunction

  always @(posedge clk or negedge reset) begin
    bit pend, popok, lg, fullnow, bc;
    if (!reset) begin
      mq.delete();
      m_head = '0; m_ovf = 0; m_bad = 0; m_stall = 0;
      m_sent = 0; m_wd = 0; m_bc = 0;
    end else begin
      pend    = (mq.size() != 0);
      popok   = bif.popin && pend;
      lg      = legal_dest(bif.dest_row, bif.dest_col);
      bc      = is_bc(bif.dest_row, bif.dest_col);
      fullnow = (mq.size() == 4);
      if (pend && !bif.popin) begin
        m_wd = (m_wd < 50) ? m_wd + 1 : 50;
        if (m_wd >= 50) m_stall = 1;
      end else begin
        m_wd = 0;
      end
      if (bif.push && !lg) m_bad = 1;
      else if (bif.push && fullnow && !popok) m_ovf = 1;
      if (popok) begin
        void'(mq.pop_front());
        m_sent++;
      end
      if (bif.push && lg && (!fullnow || popok)) begin
        mq.push_back({8'h00, bif.dest_row, bif.dest_col, (bc ? 1'b0 : bif.mode),
                      bif.payload[PW-18:0]});
        if (bc) m_bc++;
      end
      if (mq.size() != 0) m_head = mq[0];
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      chk("pndng", 64'(bif.pndng_i_in), 64'(mq.size() != 0));
      chk("full", 64'(bif.full), 64'(mq.size() == 4));
      chk("data", 64'(bif.data_out_i_in), 64'(m_head));
      chk("overflow", 64'(overflow), 64'(m_ovf));
      chk("bad_dest", 64'(bad_dest), 64'(m_bad));
      chk("stall", 64'(stall), 64'(m_stall));
      chk("sent_cnt", 64'(sent_cnt), 64'(m_sent % 65536));
`ifdef MESH_TERM_SRC_BCAST_EN
      chk("bcast_cnt", 64'(bcast_cnt), 64'(m_bc % 65536));
`endif
    end
  end

  task automatic drive(input bit p, input logic [3:0] r, input logic [3:0] c, input bit md,
                       input logic [PW-17:0] pl, input bit pp);
    bif.push = p; bif.dest_row = r; bif.dest_col = c; bif.mode = md;
    bif.payload = pl; bif.popin = pp;
  endtask

  task automatic idle();
    drive(0, 4'h0, 4'h0, 0, '0, 0);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    logic [3:0] r, c;
    idle();
    repeat (2) step();
    #2 reset = 1'b1;
    step();
    chk("rst_pndng", 64'(bif.pndng_i_in), 64'd0);
    chk("rst_data", 64'(bif.data_out_i_in), 64'd0);
    chk("rst_sent", 64'(sent_cnt), 64'd0);

    // Single push, then a one-cycle pop.
    drive(1, 4'h0, 4'h1, 0, 24'h000ABC, 0);
    step();
    chk("t1_pndng", 64'(bif.pndng_i_in), 64'd1);
    chk("t1_data", 64'(bif.data_out_i_in), 64'h00_0001_000ABC);
    drive(0, 4'h0, 4'h0, 0, '0, 1);
    step();
    chk("t1_empty", 64'(bif.pndng_i_in), 64'd0);
    chk("t1_sent", 64'(sent_cnt), 64'd1);
    idle();

    // Fill, overflow, drain in order.
    for (int k = 1; k <= 4; k++) begin
      drive(1, 4'h1, 4'h1, 0, 24'(k), 0);
      step();
    end
    chk("t2_full", 64'(bif.full), 64'd1);
    drive(1, 4'h1, 4'h1, 0, 24'd5, 0);
    step();
    chk("t2_ovf", 64'(overflow), 64'd1);
    drive(0, 4'h0, 4'h0, 0, '0, 1);
    for (int k = 1; k <= 4; k++) begin
      chk("t2_order", 64'(bif.data_out_i_in[22:0]), 64'(k));
      step();
    end
    idle();
    chk("t2_empty", 64'(bif.pndng_i_in), 64'd0);

    // Simultaneous push and pop while full.
    for (int k = 1; k <= 4; k++) begin
      drive(1, 4'h1, 4'h1, 0, 24'(k), 0);
      step();
    end
    drive(1, 4'h1, 4'h1, 0, 24'd5, 1);
    step();
    chk("t3_full", 64'(bif.full), 64'd1);
    drive(0, 4'h0, 4'h0, 0, '0, 1);
    for (int k = 2; k <= 5; k++) begin
      chk("t3_order", 64'(bif.data_out_i_in[22:0]), 64'(k));
      step();
    end
    idle();
    chk("t3_empty", 64'(bif.pndng_i_in), 64'd0);

    // Illegal destination, then a legal one.
    drive(1, 4'h7, 4'h1, 0, 24'h55, 0);
    step();
    chk("t4_bad", 64'(bad_dest), 64'd1);
    chk("t4_pndng", 64'(bif.pndng_i_in), 64'd0);
    drive(1, 4'h2, 4'h3, 1, 24'h66, 0);
    step();
    chk("t4_pndng2", 64'(bif.pndng_i_in), 64'd1);
    chk("t4_data", 64'(bif.data_out_i_in), 64'h00_0023_800066);
    idle();

    // Watchdog: 49 unserved cycles are fine, the 50th flags stall.
    repeat (49) step();
    chk("t5_stall49", 64'(stall), 64'd0);
    step();
    chk("t5_stall50", 64'(stall), 64'd1);
    drive(0, 4'h0, 4'h0, 0, '0, 1);
    step();
    idle();
    chk("t5_sticky", 64'(stall), 64'd1);
    chk("t5_empty", 64'(bif.pndng_i_in), 64'd0);

    // Fresh reset, then randomized traffic against the model.
    #2 reset = 1'b0;
    step();
    #2 reset = 1'b1;
    step();
    for (int i = 0; i < 3000; i++) begin
      r = 4'($urandom_range(0, 7));
      c = 4'($urandom_range(0, 7));
      if ($urandom_range(0, 15) == 0) begin r = 4'hF; c = 4'hF; end
      drive(bit'($urandom_range(0, 1)), r, c, bit'($urandom_range(0, 1)), 24'($urandom),
            ($urandom_range(0, 9) < (((i / 250) % 2) ? 3 : 7)));
      step();
    end

    // Drain, buffer three, then reset between edges.
    drive(0, 4'h0, 4'h0, 0, '0, 1);
    repeat (5) step();
    for (int k = 1; k <= 3; k++) begin
      drive(1, 4'h3, 4'h2, 0, 24'(k), 0);
      step();
    end
    idle();
    #2 reset = 1'b0;
    #1;
    chk("t6_pndng", 64'(bif.pndng_i_in), 64'd0);
    chk("t6_sent", 64'(sent_cnt), 64'd0);
    chk("t6_full", 64'(bif.full), 64'd0);
    step();
    #2 reset = 1'b1;
    step();
    chk("t6_empty", 64'(bif.pndng_i_in), 64'd0);
    drive(1, 4'h1, 4'h2, 0, 24'h77, 0);
    step();
    idle();
    chk("t6_push", 64'(bif.data_out_i_in), 64'h00_0012_000077);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
